// File: rtl/ddr_app_arbiter.sv
// Round-robin arbiter sharing the MIG app_* interface between one read and one write client.
// Sequences commands and write data, and counts returned read beats to close each read burst.
module ddr_app_arbiter #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic              ui_clk_i,
    input  logic              sys_rst_n,
    input  logic              calib_done_i,

    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              rd_grant_o,
    output logic              rd_done_o,

    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_data_ack_o,
    output logic              wr_grant_o,
    output logic              wr_done_o,

    input  logic              app_rdy_i,
    input  logic              app_wdf_rdy_i,
    input  logic              app_rd_data_valid_i,
    output logic              app_en_o,
    output logic [2:0]        app_cmd_o,
    output logic [ADDR_W-1:0] app_addr_o,
    output logic [DATA_W-1:0] app_wdf_data_o,
    output logic              app_wdf_wren_o,
    output logic              app_wdf_end_o
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StDrain} state_e;

    state_e             state_q, state_d;
    logic               last_wr_q, last_wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cmd_left_q, cmd_left_d;
    logic [LEN_W-1:0]   data_left_q, data_left_d;
    logic [LEN_W-1:0]   rd_ret_q, rd_ret_d;

    assign app_wdf_data_o = wr_data_i;
    assign app_addr_o     = addr_q;

    always_ff @(posedge ui_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            last_wr_q   <= 1'b1;
            addr_q      <= '0;
            len_q       <= '0;
            cmd_left_q  <= '0;
            data_left_q <= '0;
            rd_ret_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cmd_left_q  <= cmd_left_d;
            data_left_q <= data_left_d;
            rd_ret_q    <= rd_ret_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_wr_d      = last_wr_q;
        addr_d         = addr_q;
        len_d          = len_q;
        cmd_left_d     = cmd_left_q;
        data_left_d    = data_left_q;
        rd_ret_d       = rd_ret_q;
        rd_grant_o     = 1'b0;
        rd_done_o      = 1'b0;
        wr_grant_o     = 1'b0;
        wr_done_o      = 1'b0;
        wr_data_ack_o  = 1'b0;
        app_en_o       = 1'b0;
        app_cmd_o      = 3'b000;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (calib_done_i) begin
                    // On a tie the client that was not served last wins.
                    if (rd_req_i && (!wr_req_i || last_wr_q)) begin
                        state_d     = StRd;
                        addr_d      = rd_addr_i;
                        len_d       = rd_len_i;
                        cmd_left_d  = rd_len_i;
                        data_left_d = '0;
                        rd_ret_d    = '0;
                    end else if (wr_req_i) begin
                        state_d     = StWr;
                        addr_d      = wr_addr_i;
                        len_d       = wr_len_i;
                        cmd_left_d  = wr_len_i;
                        data_left_d = wr_len_i;
                        rd_ret_d    = '0;
                    end
                end
            end

            StWr: begin
                wr_grant_o     = 1'b1;
                app_en_o       = (cmd_left_q != '0);
                app_wdf_wren_o = (data_left_q != '0);
                app_wdf_end_o  = app_wdf_wren_o;
                if (app_en_o && app_rdy_i) begin
                    addr_d     = addr_q + ADDR_W'(ADDR_STEP);
                    cmd_left_d = cmd_left_q - LEN_W'(1);
                end
                if (app_wdf_wren_o && app_wdf_rdy_i) begin
                    wr_data_ack_o = 1'b1;
                    data_left_d   = data_left_q - LEN_W'(1);
                end
                if (cmd_left_q == '0 && data_left_q == '0) begin
                    wr_done_o = 1'b1;
                    state_d   = StIdle;
                    last_wr_d = 1'b1;
                end
            end

            StRd, StDrain: begin
                rd_grant_o = 1'b1;
                if (state_q == StRd) begin
                    app_cmd_o = 3'b001;
                    app_en_o  = (cmd_left_q != '0);
                    if (app_en_o && app_rdy_i) begin
                        addr_d     = addr_q + ADDR_W'(ADDR_STEP);
                        cmd_left_d = cmd_left_q - LEN_W'(1);
                    end
                    if (cmd_left_d == '0) begin
                        state_d = StDrain;
                    end
                end
                // Beats may return while commands are still being issued.
                if (app_rd_data_valid_i && rd_ret_q != len_q) begin
                    rd_ret_d = rd_ret_q + LEN_W'(1);
                end
                if (cmd_left_q == '0 && rd_ret_q == len_q) begin
                    rd_done_o = 1'b1;
                    state_d   = StIdle;
                    last_wr_d = 1'b0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Directed bench for ddr_app_arbiter: inputs change on the falling edge, outputs are
// checked 1 ns later with immediate assertions against hand-computed values.
module tb_ddr_app_arbiter;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              calib;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LEN_W-1:0]  rd_len, wr_len;
    logic [DATA_W-1:0] wr_data;
    logic              rd_grant, rd_done, wr_ack, wr_grant, wr_done;
    logic              app_rdy, app_wdf_rdy, app_rd_valid;
    logic              app_en, app_wren, app_wend;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_app_arbiter dut (
        .ui_clk_i           (clk),
        .sys_rst_n          (rst_n),
        .calib_done_i       (calib),
        .rd_req_i           (rd_req),
        .rd_addr_i          (rd_addr),
        .rd_len_i           (rd_len),
        .rd_grant_o         (rd_grant),
        .rd_done_o          (rd_done),
        .wr_req_i           (wr_req),
        .wr_addr_i          (wr_addr),
        .wr_len_i           (wr_len),
        .wr_data_i          (wr_data),
        .wr_data_ack_o      (wr_ack),
        .wr_grant_o         (wr_grant),
        .wr_done_o          (wr_done),
        .app_rdy_i          (app_rdy),
        .app_wdf_rdy_i      (app_wdf_rdy),
        .app_rd_data_valid_i(app_rd_valid),
        .app_en_o           (app_en),
        .app_cmd_o          (app_cmd),
        .app_addr_o         (app_addr),
        .app_wdf_data_o     (app_wdata),
        .app_wdf_wren_o     (app_wren),
        .app_wdf_end_o      (app_wend)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Write burst of test 2: app_rdy toggles, data side always ready.
    logic              t2_rdy  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [ADDR_W-1:0] t2_addr [6] = '{27'h7FFFFF8, 27'h7FFFFF8, 27'h0, 27'h0, 27'h8, 27'h8};
    logic              t2_ack  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; calib = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
        wr_data = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_valid = 1'b0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_rd_grant", rd_grant, 0);
        chk("rst_wr_grant", wr_grant, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_app_addr", app_addr, 0);
        chk("rst_app_wren", app_wren, 0);
        chk("rst_app_cmd", app_cmd, 0);

        // Test 1: read len 4 from 0x100
        cyc(); rst_n = 1'b1;
        cyc(); rd_req = 1'b1; rd_addr = 27'h100; rd_len = 4; app_rdy = 1'b1; #1;
        chk("t1_no_grant_yet", rd_grant, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("t1_grant", rd_grant, 1);
            chk("t1_en", app_en, 1);
            chk("t1_cmd", app_cmd, 3'b001);
            chk("t1_addr", app_addr, 27'h100 + 27'(8 * i));
        end
        cyc(); #1;
        chk("t1_drain_en", app_en, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); app_rd_valid = 1'b1; #1;
            chk("t1_done_early", rd_done, 0);
        end
        cyc(); app_rd_valid = 1'b0; #1;
        chk("t1_done", rd_done, 1);
        chk("t1_grant_at_done", rd_grant, 1);
        rd_req = 1'b0;
        cyc(); #1;
        chk("t1_grant_drop", rd_grant, 0);
        chk("t1_done_single", rd_done, 0);

        // Test 2: write len 3 wrapping the address space
        cyc(); wr_req = 1'b1; wr_addr = 27'h7FFFFF8; wr_len = 3; app_rdy = 1'b0;
        app_wdf_rdy = 1'b1; wr_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA; #1;
        chk("t2_no_grant_yet", wr_grant, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(); app_rdy = t2_rdy[i]; #1;
            chk("t2_grant", wr_grant, 1);
            chk("t2_en", app_en, 1);
            chk("t2_cmd", app_cmd, 3'b000);
            chk("t2_addr", app_addr, t2_addr[i]);
            chk("t2_ack", wr_ack, t2_ack[i]);
            chk("t2_wren", app_wren, t2_ack[i]);
            chk("t2_wend", app_wend, t2_ack[i]);
            chk("t2_done_early", wr_done, 0);
        end
        chk("t2_wdata", app_wdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        cyc(); #1;
        chk("t2_done", wr_done, 1);
        chk("t2_en_off", app_en, 0);
        wr_req = 1'b0;
        cyc(); #1;
        chk("t2_grant_drop", wr_grant, 0);

        // Test 3: simultaneous requests after reset; read wins, write follows
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc(); rd_req = 1'b1; rd_addr = 27'h40; rd_len = 1;
        wr_req = 1'b1; wr_addr = 27'h80; wr_len = 1; app_rdy = 1'b1; app_wdf_rdy = 1'b1; #1;
        chk("t3_idle", rd_grant | wr_grant, 0);
        cyc(); #1;
        chk("t3_rd_first", rd_grant, 1);
        chk("t3_wr_wait", wr_grant, 0);
        chk("t3_addr", app_addr, 27'h40);
        cyc(); app_rd_valid = 1'b1; #1;
        chk("t3_done_early", rd_done, 0);
        cyc(); app_rd_valid = 1'b0; #1;
        chk("t3_rd_done", rd_done, 1);
        rd_req = 1'b0;
        cyc(); #1;
        chk("t3_gap", wr_grant | rd_grant, 0);
        cyc(); #1;
        chk("t3_wr_grant", wr_grant, 1);
        chk("t3_wr_addr", app_addr, 27'h80);
        chk("t3_wr_ack", wr_ack, 1);
        cyc(); #1;
        chk("t3_wr_done", wr_done, 1);
        wr_req = 1'b0;
        cyc(); #1;
        chk("t3_wr_drop", wr_grant, 0);

        // Test 4: calibration gate
        calib = 1'b0; rd_req = 1'b1; rd_addr = 27'h200; rd_len = 1;
        wr_req = 1'b1; wr_addr = 27'h300; wr_len = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            chk("t4_no_grant", rd_grant | wr_grant, 0);
            chk("t4_no_en", app_en, 0);
        end
        calib = 1'b1;
        cyc(); #1;
        chk("t4_rd_grant", rd_grant, 1);
        chk("t4_wr_wait", wr_grant, 0);
        cyc(); app_rd_valid = 1'b1; #1;
        cyc(); app_rd_valid = 1'b0; #1;
        chk("t4_rd_done", rd_done, 1);
        rd_req = 1'b0; wr_req = 1'b0;
        cyc(); #1;
        chk("t4_idle", rd_grant | wr_grant, 0);

        // Test 5: zero-length write
        cyc(); wr_req = 1'b1; wr_addr = 27'h500; wr_len = 0; #1;
        cyc(); #1;
        chk("t5_grant", wr_grant, 1);
        chk("t5_done", wr_done, 1);
        chk("t5_no_en", app_en, 0);
        chk("t5_no_wren", app_wren, 0);
        wr_req = 1'b0;
        cyc(); #1;
        chk("t5_grant_drop", wr_grant, 0);
        chk("t5_done_drop", wr_done, 0);
        chk("t5_no_en_after", app_en | app_wren, 0);

        // Test 6: reset mid read burst, stray valids, then a fresh len 2 read
        cyc(); rd_req = 1'b1; rd_addr = 27'h300; rd_len = 8; app_rdy = 1'b1; #1;
        cyc(); #1;
        chk("t6_addr0", app_addr, 27'h300);
        cyc(); #1;
        chk("t6_addr1", app_addr, 27'h308);
        cyc(); rst_n = 1'b0; rd_req = 1'b0; #1;
        chk("t6_rst_grant", rd_grant, 0);
        chk("t6_rst_en", app_en, 0);
        chk("t6_rst_addr", app_addr, 0);
        chk("t6_rst_cmd", app_cmd, 0);
        cyc(); rst_n = 1'b1; app_rd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("t6_stray_done", rd_done, 0);
            chk("t6_stray_grant", rd_grant, 0);
        end
        cyc(); app_rd_valid = 1'b0; rd_req = 1'b1; rd_addr = 27'h400; rd_len = 2; #1;
        cyc(); #1;
        chk("t6_new_addr0", app_addr, 27'h400);
        cyc(); #1;
        chk("t6_new_addr1", app_addr, 27'h408);
        cyc(); app_rd_valid = 1'b1; #1;
        chk("t6_drain_en", app_en, 0);
        chk("t6_done_early0", rd_done, 0);
        cyc(); #1;
        chk("t6_done_early1", rd_done, 0);
        cyc(); app_rd_valid = 1'b0; #1;
        chk("t6_done", rd_done, 1);
        rd_req = 1'b0;
        cyc(); #1;
        chk("t6_grant_drop", rd_grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
